// File: rtl/tw_addr_gen_if.sv
// Handshake and status bundle between the twiddle address generator and its
// consumers (twiddle ROM, butterfly unit, memory/control path).
interface tw_addr_gen_if #(
    parameter int unsigned WN = 3
) ();
    logic          iSTART;
    logic          iREADY;
    logic [WN-1:0] twiddle_addr;
    logic          oVALID;
    logic [1:0]    oSTAGE;
    logic [2:0]    oBF_IDX;
    logic          oSTAGE_DONE;
    logic          oDONE;
    logic          oBUSY;

    modport master (
        input  iSTART,
        input  iREADY,
        output twiddle_addr,
        output oVALID,
        output oSTAGE,
        output oBF_IDX,
        output oSTAGE_DONE,
        output oDONE,
        output oBUSY
    );

    modport slave (
        output iSTART,
        output iREADY,
        input  twiddle_addr,
        input  oVALID,
        input  oSTAGE,
        input  oBF_IDX,
        input  oSTAGE_DONE,
        input  oDONE,
        input  oBUSY
    );
endinterface

// File: rtl/tw_addr_gen.sv
// Twiddle ROM address sequencer for the 16-point radix-2 DIF FFT: walks
// 4 stages x 8 butterflies under valid/ready backpressure.
module tw_addr_gen #(
    parameter int unsigned WN = 3,
    parameter int unsigned NS = 4
) (
    input  logic         iCLK,
    input  logic         iRSTn,
    tw_addr_gen_if.master bus
);
    localparam int unsigned SW = 2;
    localparam int unsigned BW = 3;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t        state,      stateNext;
    logic [SW-1:0] stage,      stageNext;
    logic [BW-1:0] bfIdx,      bfIdxNext;
    logic [WN-1:0] addr,       addrNext;
    logic          valid,      validNext;
    logic          busy,       busyNext;
    logic          stageDone,  stageDoneNext;
    logic          done,       doneNext;
    logic [BW-1:0] bfInc;

    assign bfInc = bfIdx + 3'd1;

    // State and all output registers
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state     <= IDLE;
            stage     <= '0;
            bfIdx     <= '0;
            addr      <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            stageDone <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= stateNext;
            stage     <= stageNext;
            bfIdx     <= bfIdxNext;
            addr      <= addrNext;
            valid     <= validNext;
            busy      <= busyNext;
            stageDone <= stageDoneNext;
            done      <= doneNext;
        end
    end

    // Next-state and next-output decode; strobes default low so they never hold
    always_comb begin
        stateNext     = state;
        stageNext     = stage;
        bfIdxNext     = bfIdx;
        addrNext      = addr;
        validNext     = valid;
        busyNext      = busy;
        stageDoneNext = 1'b0;
        doneNext      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.iSTART) begin
                    stateNext = RUN;
                    validNext = 1'b1;
                    busyNext  = 1'b1;
                    stageNext = '0;
                    bfIdxNext = '0;
                    addrNext  = '0;
                end
            end
            RUN: begin
                if (valid && bus.iREADY) begin
                    if (bfIdx == 3'd7) begin
                        stageDoneNext = 1'b1;
                        bfIdxNext     = '0;
                        addrNext      = '0;
                        if (stage == SW'(NS - 1)) begin
                            stateNext = FLUSH;
                            validNext = 1'b0;
                            doneNext  = 1'b1;
                        end else begin
                            stageNext = stage + 2'd1;
                        end
                    end else begin
                        bfIdxNext = bfInc;
                        // Dropping the top s bits of j<<s is the same as (j mod (8>>s))<<s
                        addrNext  = WN'(bfInc << stage);
                    end
                end
            end
            FLUSH: begin
                stateNext = IDLE;
                validNext = 1'b0;
                busyNext  = 1'b0;
                stageNext = '0;
                bfIdxNext = '0;
                addrNext  = '0;
            end
            default: begin
                stateNext = IDLE;
                validNext = 1'b0;
                busyNext  = 1'b0;
                stageNext = '0;
                bfIdxNext = '0;
                addrNext  = '0;
            end
        endcase
    end

    assign bus.twiddle_addr = addr;
    assign bus.oVALID       = valid;
    assign bus.oSTAGE       = stage;
    assign bus.oBF_IDX      = bfIdx;
    assign bus.oSTAGE_DONE  = stageDone;
    assign bus.oDONE        = done;
    assign bus.oBUSY        = busy;
endmodule

// File: tb/tb_tw_addr_gen.sv
// Self-checking bench for tw_addr_gen: directed frames with random backpressure
// checked against an arithmetic model of the twiddle sequence.
module tb_tw_addr_gen;
    logic iCLK = 1'b0;
    logic iRSTn;
    int   nCmp = 0;
    int   nErr = 0;
    int   expAddr [32];

    tw_addr_gen_if #(.WN(3)) bus ();

    tw_addr_gen #(.WN(3), .NS(4)) dut (
        .iCLK  (iCLK),
        .iRSTn (iRSTn),
        .bus   (bus)
    );

    always #5 iCLK = ~iCLK;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input int v, input int b, input int a,
                          input int s, input int j, input int sd, input int d);
        chk({tag, "_valid"}, 32'(bus.oVALID), 32'(v));
        chk({tag, "_busy"},  32'(bus.oBUSY),  32'(b));
        chk({tag, "_addr"},  32'(bus.twiddle_addr), 32'(a));
        chk({tag, "_stage"}, 32'(bus.oSTAGE), 32'(s));
        chk({tag, "_bf"},    32'(bus.oBF_IDX), 32'(j));
        chk({tag, "_sdone"}, 32'(bus.oSTAGE_DONE), 32'(sd));
        chk({tag, "_done"},  32'(bus.oDONE),  32'(d));
    endtask

    // Starts a frame from an IDLE sample point and follows it to the next IDLE.
    task automatic doFrame(input string tag, input bit randRdy, input int spurK,
                           input int stallK, input int abortK, input bit lateStart);
        int k;
        int cyc;
        int stallCnt;
        int sdExp;
        bit r;
        k = 0; cyc = 0; stallCnt = 0; sdExp = 0;
        bus.iSTART = 1'b1;
        bus.iREADY = 1'b0;
        step();
        bus.iSTART = 1'b0;
        cyc = 1;
        while (k < 32) begin
            chkAll({tag, "_run"}, 1, 1, expAddr[k], k / 8, k % 8, sdExp, 0);
            if (k == abortK) begin
                #3 iRSTn = 1'b0;
                #1;
                chkAll({tag, "_abort"}, 0, 0, 0, 0, 0, 0, 0);
                step();
                step();
                chkAll({tag, "_inrst"}, 0, 0, 0, 0, 0, 0, 0);
                #2 iRSTn = 1'b1;
                step();
                chkAll({tag, "_postrst"}, 0, 0, 0, 0, 0, 0, 0);
                return;
            end
            if (k == stallK && stallCnt < 5) begin
                r = 1'b0;
                stallCnt++;
            end else if (randRdy) begin
                r = 1'($urandom_range(0, 1));
            end else begin
                r = 1'b1;
            end
            bus.iREADY = r;
            bus.iSTART = (k == spurK);
            step();
            bus.iSTART = 1'b0;
            cyc++;
            sdExp = (r && (k % 8 == 7)) ? 1 : 0;
            if (r) k++;
            if (cyc > 400) begin
                chk({tag, "_budget"}, 32'(cyc), 32'd400);
                return;
            end
        end
        chk({tag, "_fl_valid"}, 32'(bus.oVALID), 32'd0);
        chk({tag, "_fl_busy"},  32'(bus.oBUSY), 32'd1);
        chk({tag, "_fl_sdone"}, 32'(bus.oSTAGE_DONE), 32'd1);
        chk({tag, "_fl_done"},  32'(bus.oDONE), 32'd1);
        if (!randRdy && stallK < 0) chk({tag, "_latency"}, 32'(cyc), 32'd33);
        bus.iREADY = 1'($urandom_range(0, 1));
        bus.iSTART = lateStart;
        step();
        bus.iSTART = 1'b0;
        chkAll({tag, "_idle"}, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int s = 0; s < 4; s++)
            for (int j = 0; j < 8; j++)
                expAddr[s * 8 + j] = (j % (8 >> s)) << s;

        iRSTn      = 1'b0;
        bus.iSTART = 1'b0;
        bus.iREADY = 1'b0;
        repeat (3) step();
        chkAll("rst", 0, 0, 0, 0, 0, 0, 0);
        #2 iRSTn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.iREADY = 1'($urandom_range(0, 1));
            step();
            chkAll("rst_idle", 0, 0, 0, 0, 0, 0, 0);
        end

        // Full-rate frame; start pulsed during FLUSH must be ignored
        doFrame("full", 1'b0, -1, -1, -1, 1'b1);
        // Immediately restart from IDLE with backpressure, boundary stall and spurious start
        doFrame("bp", 1'b1, 19, 15, -1, 1'b0);
        // Abort at stage 1, j=4
        doFrame("abort", 1'b1, -1, -1, 12, 1'b0);
        // Clean frame after reset
        doFrame("clean", 1'b0, -1, -1, -1, 1'b0);
        // Another random-backpressure frame
        doFrame("bp2", 1'b1, -1, -1, -1, 1'b0);

        repeat (3) begin
            step();
            chkAll("tail", 0, 0, 0, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
